// File: rtl/risc_v_mike_wb_pkg.sv
// Shared types for the writeback unit: register address, data width, FIFO entry.
package risc_v_mike_wb_pkg;

  localparam int unsigned DATA_32_W  = 32;
  localparam int unsigned REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] t_register_addr;

  typedef struct packed {
    t_register_addr        addr;
    logic [DATA_32_W-1:0]  data;
  } t_wb_entry;

  // Writes to x0 are architecturally discarded.
  function automatic logic is_x0(t_register_addr addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/risc_v_mike_wb_fifo.sv
// Synchronous FIFO of writeback entries; DEPTH must be a power of 2 and >= 2.
module risc_v_mike_wb_fifo
  import risc_v_mike_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  t_wb_entry              push_data,
  input  logic                   pop,
  output t_wb_entry              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  t_wb_entry        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/risc_v_mike_wb_unit.sv
// Writeback arbiter: ALU stream (priority, no backpressure) merged with a
// FIFO-buffered LSU stream, plus destination scoreboard and starvation stall.
// Optional macro MIKE_WB_LSU_BYPASS_EN lets an LSU result skip the empty FIFO
// when the ALU is idle.
module risc_v_mike_wb_unit
  import risc_v_mike_wb_pkg::*;
#(
  parameter int unsigned REG_FILE_DEPTH = 16,
  parameter int unsigned WB_FIFO_DEPTH  = 4,
  parameter int unsigned WB_STARVE_MAX  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_wb_valid,
  input  t_register_addr            alu_wb_addr,
  input  logic [DATA_32_W-1:0]      alu_wb_data,
  input  logic                      lsu_wb_valid,
  output logic                      lsu_wb_ready,
  input  t_register_addr            lsu_wb_addr,
  input  logic [DATA_32_W-1:0]      lsu_wb_data,
  input  logic                      iss_valid,
  input  t_register_addr            iss_addr,
  output logic                      reg_file_write,
  output t_register_addr            reg_file_wr_addr,
  output logic [DATA_32_W-1:0]      reg_file_wr_data,
  output logic [REG_FILE_DEPTH-1:0] reg_pending,
  output logic                      wb_stall
);

  localparam int unsigned STARVE_W = 8;
  localparam int unsigned CNT_W    = $clog2(WB_FIFO_DEPTH) + 1;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_nonempty;
  t_wb_entry                 fifo_head;
  t_wb_entry                 lsu_entry;
  t_wb_entry                 alu_entry;
  t_wb_entry                 sel_entry;
  logic                      sel_valid;
  logic                      lsu_accept;
  logic [STARVE_W-1:0]       starve_cnt;
  logic [STARVE_W-1:0]       starve_nxt;
  logic [REG_FILE_DEPTH-1:0] pending_nxt;

  assign lsu_wb_ready  = !fifo_full;
  assign lsu_accept    = lsu_wb_valid && lsu_wb_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign lsu_entry     = '{addr: lsu_wb_addr, data: lsu_wb_data};
  assign alu_entry     = '{addr: alu_wb_addr, data: alu_wb_data};

  risc_v_mike_wb_fifo #(
    .DEPTH (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lsu_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Source select: ALU first, then FIFO head, then (optionally) the live LSU offer.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    fifo_pop  = 1'b0;
    fifo_push = lsu_accept;
    if (alu_wb_valid) begin
      sel_valid = 1'b1;
      sel_entry = alu_entry;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
    end
`ifdef MIKE_WB_LSU_BYPASS_EN
    else if (lsu_accept) begin
      sel_valid = 1'b1;
      sel_entry = lsu_entry;
      fifo_push = 1'b0;
    end
`endif
  end

  // Scoreboard next state; a new issue to the same register outranks the clear.
  always_comb begin
    pending_nxt = reg_pending;
    if (sel_valid) pending_nxt[sel_entry.addr] = 1'b0;
    if (iss_valid && !is_x0(iss_addr)) pending_nxt[iss_addr] = 1'b1;
  end

  // Starvation count of consecutive cycles the FIFO is blocked by the ALU.
  always_comb begin
    starve_nxt = '0;
    if (fifo_nonempty && alu_wb_valid) begin
      if (starve_cnt >= STARVE_W'(WB_STARVE_MAX)) starve_nxt = starve_cnt;
      else                                        starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  // Registered write port, scoreboard, counter and stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_file_write   <= 1'b0;
      reg_file_wr_addr <= '0;
      reg_file_wr_data <= '0;
      reg_pending      <= '0;
      starve_cnt       <= '0;
      wb_stall         <= 1'b0;
    end else begin
      reg_file_write   <= sel_valid && !is_x0(sel_entry.addr);
      reg_file_wr_addr <= sel_entry.addr;
      reg_file_wr_data <= sel_entry.data;
      reg_pending      <= pending_nxt;
      starve_cnt       <= starve_nxt;
      wb_stall         <= (starve_nxt == STARVE_W'(WB_STARVE_MAX));
    end
  end

endmodule

// File: tb/tb_risc_v_mike_wb_unit.sv
// Self-checking bench for risc_v_mike_wb_unit: directed vector table, hand
// sequences for the multi-cycle corners, and randomized traffic against a
// queue-based reference model.
module tb_risc_v_mike_wb_unit;
  import risc_v_mike_wb_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;
`ifdef MIKE_WB_LSU_BYPASS_EN
  localparam int LSU_LAT = 1;
`else
  localparam int LSU_LAT = 2;
`endif

  logic                 clk;
  logic                 rst;
  logic                 alu_wb_valid;
  t_register_addr       alu_wb_addr;
  logic [DATA_32_W-1:0] alu_wb_data;
  logic                 lsu_wb_valid;
  logic                 lsu_wb_ready;
  t_register_addr       lsu_wb_addr;
  logic [DATA_32_W-1:0] lsu_wb_data;
  logic                 iss_valid;
  t_register_addr       iss_addr;
  logic                 reg_file_write;
  t_register_addr       reg_file_wr_addr;
  logic [DATA_32_W-1:0] reg_file_wr_data;
  logic [15:0]          reg_pending;
  logic                 wb_stall;

  risc_v_mike_wb_unit #(
    .REG_FILE_DEPTH (16),
    .WB_FIFO_DEPTH  (DEPTH),
    .WB_STARVE_MAX  (STARVE_MAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_wb_valid     (alu_wb_valid),
    .alu_wb_addr      (alu_wb_addr),
    .alu_wb_data      (alu_wb_data),
    .lsu_wb_valid     (lsu_wb_valid),
    .lsu_wb_ready     (lsu_wb_ready),
    .lsu_wb_addr      (lsu_wb_addr),
    .lsu_wb_data      (lsu_wb_data),
    .iss_valid        (iss_valid),
    .iss_addr         (iss_addr),
    .reg_file_write   (reg_file_write),
    .reg_file_wr_addr (reg_file_wr_addr),
    .reg_file_wr_data (reg_file_wr_data),
    .reg_pending      (reg_pending),
    .wb_stall         (wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: FIFO as a queue, pending set as a bit array.
  t_wb_entry      mq[$];
  logic [15:0]    mpend;
  int             mstarve;
  logic           e_write;
  t_register_addr e_addr;
  logic [31:0]    e_data;
  logic           e_stall;

  int n_pass;
  int n_total;

  typedef struct {
    logic           alu_v;
    t_register_addr alu_a;
    logic [31:0]    alu_d;
    logic           iss_v;
    t_register_addr iss_a;
    logic           x_write;
    t_register_addr x_addr;
    logic [31:0]    x_data;
    logic [15:0]    x_pend;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_addr = '0; lsu_wb_data = '0;
    iss_valid    = 1'b0; iss_addr    = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    mpend   = '0;
    mstarve = 0;
  endtask

  // One clock: predict from the rules, advance, then compare everything.
  task automatic tick();
    t_wb_entry e;
    logic      acc;
    logic      sel;
    logic      was_nonempty;
    chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(mq.size() < DEPTH));
    acc          = lsu_wb_valid && (mq.size() < DEPTH);
    was_nonempty = (mq.size() != 0);
    sel          = 1'b0;
    e            = '0;
    if (alu_wb_valid) begin
      sel = 1'b1; e.addr = alu_wb_addr; e.data = alu_wb_data;
    end else if (mq.size() != 0) begin
      sel = 1'b1; e = mq.pop_front();
    end
`ifdef MIKE_WB_LSU_BYPASS_EN
    else if (acc) begin
      sel = 1'b1; e.addr = lsu_wb_addr; e.data = lsu_wb_data; acc = 1'b0;
    end
`endif
    if (acc) mq.push_back('{addr: lsu_wb_addr, data: lsu_wb_data});
    if (was_nonempty && alu_wb_valid) mstarve = (mstarve < STARVE_MAX) ? mstarve + 1 : STARVE_MAX;
    else                              mstarve = 0;
    if (sel) mpend[e.addr] = 1'b0;
    if (iss_valid && iss_addr != '0) mpend[iss_addr] = 1'b1;
    e_write = sel && (e.addr != '0);
    e_addr  = e.addr;
    e_data  = e.data;
    e_stall = (mstarve == STARVE_MAX);
    @(posedge clk); #1;
    chk("reg_file_write", 32'(reg_file_write), 32'(e_write));
    if (e_write) begin
      chk("reg_file_wr_addr", 32'(reg_file_wr_addr), 32'(e_addr));
      chk("reg_file_wr_data", reg_file_wr_data, e_data);
    end
    chk("reg_pending", 32'(reg_pending), 32'(mpend));
    chk("wb_stall", 32'(wb_stall), 32'(e_stall));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_write"}, 32'(reg_file_write), 32'd0);
    chk({tag, "_addr"},  32'(reg_file_wr_addr), 32'd0);
    chk({tag, "_data"},  reg_file_wr_data, 32'd0);
    chk({tag, "_pending"}, 32'(reg_pending), 32'd0);
    chk({tag, "_stall"}, 32'(wb_stall), 32'd0);
    chk({tag, "_ready"}, 32'(lsu_wb_ready), 32'd1);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  // Offer one LSU result with the ALU idle and measure cycles to the write.
  task automatic lsu_probe(input t_register_addr a, input logic [31:0] d, input logic chk_pend);
    int lat;
    idle_inputs();
    lsu_wb_valid = 1'b1; lsu_wb_addr = a; lsu_wb_data = d;
    tick();
    idle_inputs();
    lat = 1;
    while (reg_file_write !== 1'b1 && lat < 10) begin
      if (chk_pend) chk("pending_outstanding", 32'(reg_pending[a]), 32'd1);
      tick();
      lat++;
    end
    chk("lsu_latency", 32'(lat), 32'(LSU_LAT));
    chk("lsu_probe_addr", 32'(reg_file_wr_addr), 32'(a));
    chk("lsu_probe_data", reg_file_wr_data, d);
    if (chk_pend) chk("pending_cleared", 32'(reg_pending[a]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    idle_inputs();

    vt[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b1, 4'd5, 32'hDEADBEEF, 16'h0000};
    vt[1] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd3, 1'b0, 4'd0, 32'h0,        16'h0008};
    vt[2] = '{1'b1, 4'd3, 32'h00000033, 1'b1, 4'd3, 1'b1, 4'd3, 32'h00000033, 16'h0008};
    vt[3] = '{1'b1, 4'd3, 32'h00000044, 1'b0, 4'd0, 1'b1, 4'd3, 32'h00000044, 16'h0000};
    vt[4] = '{1'b1, 4'd0, 32'h00000099, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0,        16'h0000};
    vt[5] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd0, 1'b0, 4'd0, 32'h0,        16'h0000};
    vt[6] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 1'b0, 4'd0, 32'h0,        16'h0080};

    do_reset();

    // Directed ALU / scoreboard vectors with hand-computed expectations.
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      alu_wb_valid = vt[i].alu_v; alu_wb_addr = vt[i].alu_a; alu_wb_data = vt[i].alu_d;
      iss_valid    = vt[i].iss_v; iss_addr    = vt[i].iss_a;
      tick();
      chk("vec_write", 32'(reg_file_write), 32'(vt[i].x_write));
      if (vt[i].x_write) begin
        chk("vec_addr", 32'(reg_file_wr_addr), 32'(vt[i].x_addr));
        chk("vec_data", reg_file_wr_data, vt[i].x_data);
      end
      chk("vec_pending", 32'(reg_pending), 32'(vt[i].x_pend));
    end

    // Issue reg 7, then LSU result for reg 7 with the ALU idle.
    do_reset();
    idle_inputs();
    iss_valid = 1'b1; iss_addr = 4'd7;
    tick();
    chk("iss7_pending", 32'(reg_pending[7]), 32'd1);
    lsu_probe(4'd7, 32'h12345678, 1'b1);

    // Fill the FIFO behind a continuously valid ALU, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      alu_wb_valid = 1'b1; alu_wb_addr = 4'd9; alu_wb_data = $urandom;
      lsu_wb_valid = (i < 5); lsu_wb_addr = 4'(i + 1); lsu_wb_data = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 3) chk("fifo_full_ready", 32'(lsu_wb_ready), 32'd0);
      chk("starve_stall", 32'(wb_stall), 32'(i >= 8));
    end
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      tick();
      chk("drain_write", 32'(reg_file_write), 32'd1);
      chk("drain_addr", 32'(reg_file_wr_addr), 32'(i + 1));
      chk("drain_data", reg_file_wr_data, 32'hA000_0000 + 32'(i));
    end
    tick();
    chk("drained_idle", 32'(reg_file_write), 32'd0);

    // Both streams target x0: no write, and the FIFO entry is still consumed.
    idle_inputs();
    alu_wb_valid = 1'b1; alu_wb_addr = 4'd0; alu_wb_data = 32'h1;
    lsu_wb_valid = 1'b1; lsu_wb_addr = 4'd0; lsu_wb_data = 32'h2;
    tick();
    chk("x0_alu_write", 32'(reg_file_write), 32'd0);
    idle_inputs();
    tick();
    chk("x0_lsu_write", 32'(reg_file_write), 32'd0);
    lsu_probe(4'd6, 32'h0000_0066, 1'b0);

    // Reset asserted mid-operation with FIFO entries and pending bits live.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      alu_wb_valid = 1'b1; alu_wb_addr = 4'd9; alu_wb_data = 32'h9;
      lsu_wb_valid = 1'b1; lsu_wb_addr = 4'(i + 1); lsu_wb_data = 32'(i);
      iss_valid = 1'b1; iss_addr = 4'(10 + i);
      tick();
    end
    chk("pre_reset_pending", 32'(reg_pending), 32'h1C00);
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    idle_inputs();
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_nowrite", 32'(reg_file_write), 32'd0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      alu_wb_valid = ($urandom_range(0, 99) < (wb_stall ? 20 : 50));
      alu_wb_addr  = 4'($urandom_range(0, 15));
      alu_wb_data  = $urandom;
      lsu_wb_valid = ($urandom_range(0, 99) < 50);
      lsu_wb_addr  = 4'($urandom_range(0, 15));
      lsu_wb_data  = $urandom;
      iss_valid    = ($urandom_range(0, 99) < 30);
      iss_addr     = 4'($urandom_range(0, 15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
